uart_tap_tx: RTL and testbench
==============================

UART_TAP_TX -- requirements
Module: uart_tap_tx

Interface
REQ-001 Parameter SYSTEM_CLOCK, default 32000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate; bit period DIV = SYSTEM_CLOCK/BAUD_RATE clocks (integer, truncated).
REQ-003 Parameter FIFO_DEPTH, default 16, capture FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ch0_valid  input  1  one-cycle strobe, byte sniffed on the B1->B2 path.
REQ-007 ch0_data  input  8  byte qualified by ch0_valid.
REQ-008 ch1_valid  input  1  one-cycle strobe, byte sniffed on the B2->B1 path.
REQ-009 ch1_data  input  8  byte qualified by ch1_valid.
REQ-010 dout  output  1  8N1 serial line to the PC; idle high.
REQ-011 busy  output  1  high while the FIFO is non-empty or a frame is in flight.
REQ-012 overflow  output  1  sticky flag, set on first dropped byte.
REQ-013 drop_cnt  output  8  count of dropped bytes, saturating at 255.

Function
REQ-014 Each capture SHALL be stored as a 9-bit entry {src, data}, with src=0 for ch0 and src=1 for ch1.
REQ-015 When only one channel strobes, its entry SHALL be written to the FIFO on that edge if the FIFO is not full.
REQ-016 When both channels strobe in the same cycle, ch0 SHALL be written first; ch1 SHALL be parked in a one-entry hold register and written on the next edge.
REQ-017 A hold-register write SHALL take priority over a new strobe; any new strobe arriving that cycle SHALL be parked in turn, so a strobe is never lost while FIFO space exists.
REQ-018 A write attempt to a full FIFO SHALL drop the entry, set overflow, and increment drop_cnt (saturating at 255).
REQ-019 A pop and a push to a full FIFO in the same cycle SHALL both succeed, with no drop.
REQ-020 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, wrap modulo 2*FIFO_DEPTH, and compute full/empty from MSB-differs/equal.
REQ-021 The sequencer FSM SHALL have states S_IDLE, S_TAG, S_DATA and S_WAIT.
  - S_IDLE: if the FIFO is non-empty, pop and go to S_TAG.
  - S_TAG: when the serializer is ready, send tag 0x41 ('A') for src=0 or 0x42 ('B') for src=1, then go to S_DATA.
  - S_DATA: when ready, send the data byte, then go to S_WAIT.
  - S_WAIT: when the serializer is ready again, return to S_IDLE.
REQ-022 The serializer SHALL emit, LSB first, a start bit (0), 8 data bits, and 1 stop bit (1); each bit lasts DIV clocks.
REQ-023 The serializer handshake SHALL be: en is sampled only while rdy=1; rdy drops on the next edge and rises again after the stop bit completes.
REQ-024 Latency: with the FIFO empty and the line idle, the start bit of the tag SHALL appear no later than 3 edges after the valid strobe.
REQ-025 Back-to-back frames SHALL contain no extra idle bit between the stop bit and the next start bit.

Reset
REQ-026 While rst=0, the following SHALL hold asynchronously:
  - dout=1, busy=0, overflow=0, drop_cnt=0;
  - FIFO empty, hold register empty;
  - FSM in S_IDLE, serializer idle with rdy=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (dout returns high) and discard all FIFO contents.
REQ-028 Reset deassertion SHALL be synchronised so the first active edge occurs cleanly; strobes on that edge SHALL be accepted.

Configuration
REQ-029 Macro UART_TAP_TAG_EN:
  - Defined: frames are the tag byte followed by the data byte, per REQ-021.
  - Undefined: S_TAG is bypassed, only the data byte is sent, and src is still stored but ignored.

Structure
REQ-030 A shared package SHALL hold the tag constants (0x41, 0x42), the FSM state encoding, and the 9-bit entry type.
REQ-031 The serializer SHALL be a sub-module, uart_tap_ser, with the en/data_in/rdy/dout handshake; the FIFO and sequencer SHALL be inline.

Verification (SYSTEM_CLOCK=32000000, BAUD_RATE=9600, DIV=3333)
REQ-032 ch0_valid with 0x5A -> dout carries 0x41 then 0x5A, each bit 3333 clocks; busy is high for 20 bit periods.
REQ-033 ch0=0x11 and ch1=0x22 in the same cycle -> line order 'A',0x11,'B',0x22.
REQ-034 20 ch1 strobes 1 clock apart, FIFO_DEPTH=16 -> the first 17 bytes are sent (one is in flight), overflow=1, drop_cnt=3.
REQ-035 300 drops -> drop_cnt saturates at 255.
REQ-036 rst=0 in the middle of a data bit -> dout=1 the same cycle; after release, a new strobe of 0x33 is sent cleanly.
REQ-037 With UART_TAP_TAG_EN undefined, ch1 strobe with 0xA5 -> only 0xA5 appears, in 10 bit periods.

Source files
------------

// File: rtl/uart_tap_pkg.sv
// Shared types and constants for the UART bus tap: FIFO entry layout, tag bytes
// and the sequencer state encoding.
`timescale 1ns/1ps
package uart_tap_pkg;

  localparam logic [7:0] TAG_CH0 = 8'h41;  // 'A', B1->B2 traffic
  localparam logic [7:0] TAG_CH1 = 8'h42;  // 'B', B2->B1 traffic

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_DATA = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } entry_t;

  function automatic logic [7:0] tag_for(input logic src);
    return src ? TAG_CH1 : TAG_CH0;
  endfunction

endpackage

// File: rtl/uart_tap_ser.sv
// 8N1 serializer, LSB first, DIV clocks per bit. rdy is also high during the final
// clock of the stop bit so a waiting byte starts with no idle gap.
`timescale 1ns/1ps
module uart_tap_ser #(
  parameter int DIV = 3333
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic       rdy,
  output logic       dout
);

  localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  logic             busy_q, busy_d;
  logic             dout_q, dout_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             last_tick;

  assign last_tick = busy_q && (bit_cnt_q == 4'd9) && (baud_cnt_q == BAUD_LAST);
  assign rdy       = !busy_q || last_tick;
  assign dout      = dout_q;

  // NOTE: every signal written here gets a default first, otherwise paths that
  // skip an assignment would infer latches.
  always_comb begin
    busy_d     = busy_q;
    dout_d     = dout_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    if (en && rdy) begin
      busy_d     = 1'b1;
      dout_d     = 1'b0;
      shift_d    = {1'b1, data_in};
      bit_cnt_d  = 4'd0;
      baud_cnt_d = '0;
    end else if (busy_q) begin
      if (baud_cnt_q == BAUD_LAST) begin
        baud_cnt_d = '0;
        if (bit_cnt_q == 4'd9) begin
          busy_d = 1'b0;
        end else begin
          // Stop bit rides in at the top of the shift register.
          dout_d    = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end else begin
        baud_cnt_d = baud_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      dout_q     <= 1'b1;
      shift_q    <= '1;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tap_tx.sv
// Bus tap: captures bytes from two sniffed channels into a FIFO and streams them
// out over 8N1. Define UART_TAP_TAG_EN to prefix each byte with an 'A'/'B' tag.
`timescale 1ns/1ps
module uart_tap_tx
  import uart_tap_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 32000000,
  parameter int BAUD_RATE    = 9600,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_data,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_data,
  output logic       dout,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int DIV   = SYSTEM_CLOCK / BAUD_RATE;
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  // Assertion is immediate; release is re-timed to clk so the first edge is clean.
  logic rst_meta_q, rst_sync_q, rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rst_sync_q, rst_meta_q} <= 2'b00;
    else      {rst_sync_q, rst_meta_q} <= {rst_meta_q, 1'b1};
  end
  assign rst_n = rst_sync_q;

  entry_t             fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               fifo_full, fifo_empty;
  entry_t             hold_q, hold_d, wr_entry, ch0_e, ch1_e;
  logic               hold_v_q, hold_v_d;
  logic               wr_req, push, pop, lost;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [8:0]         drop_sum;
  state_e             state_q, state_d;
  entry_t             cur_q, cur_d;
  logic               ser_en, ser_rdy;
  logic [7:0]         ser_data;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign ch0_e      = '{src: 1'b0, data: ch0_data};
  assign ch1_e      = '{src: 1'b1, data: ch1_data};

  // One write port: a parked entry goes first and any fresh strobe takes its place.
  always_comb begin
    wr_req   = 1'b0;
    wr_entry = '0;
    hold_v_d = 1'b0;
    hold_d   = hold_q;
    lost     = 1'b0;
    if (hold_v_q) begin
      wr_req   = 1'b1;
      wr_entry = hold_q;
      if (ch0_valid) begin
        hold_v_d = 1'b1;
        hold_d   = ch0_e;
        lost     = ch1_valid;
      end else if (ch1_valid) begin
        hold_v_d = 1'b1;
        hold_d   = ch1_e;
      end
    end else if (ch0_valid) begin
      wr_req   = 1'b1;
      wr_entry = ch0_e;
      if (ch1_valid) begin
        hold_v_d = 1'b1;
        hold_d   = ch1_e;
      end
    end else if (ch1_valid) begin
      wr_req   = 1'b1;
      wr_entry = ch1_e;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = wr_req && (!fifo_full || pop);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

  assign drop_sum   = {1'b0, drop_cnt_q} + 9'(wr_req && !push) + 9'(lost);
  assign drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  assign overflow_d = overflow_q || (wr_req && !push) || lost;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    pop      = 1'b0;
    ser_en   = 1'b0;
    ser_data = cur_q.data;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          cur_d = fifo_mem_q[rd_ptr_q[PTR_W-2:0]];
`ifdef UART_TAP_TAG_EN
          state_d = S_TAG;
`else
          state_d = S_DATA;
`endif
        end
      end
      S_TAG: begin
        ser_data = tag_for(cur_q.src);
        if (ser_rdy) begin
          ser_en  = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ser_rdy) begin
          ser_en  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ser_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; emptiness is carried by the pointers,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PTR_W-2:0]] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= S_IDLE;
      cur_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
    end
  end

  uart_tap_ser #(.DIV(DIV)) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ser_en),
    .data_in (ser_data),
    .rdy     (ser_rdy),
    .dout    (dout)
  );

  assign busy     = !fifo_empty || hold_v_q || (state_q != S_IDLE);
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_tap_tx.sv
// Directed bench for uart_tap_tx: a line decoder collects sent bytes and the
// checks compare them, plus status outputs, against hand-computed values.
`timescale 1ns/1ps
module tb_uart_tap_tx;

  localparam int SYS   = 40;
  localparam int BAUD  = 10;
  localparam int DIV   = SYS / BAUD;
  localparam int DEPTH = 16;
`ifdef UART_TAP_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int FRAMES = TAG_EN ? 2 : 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [7:0] ch0_data = 8'h00, ch1_data = 8'h00;
  logic       dout, busy, overflow;
  logic [7:0] drop_cnt;

  int         n_checks = 0;
  int         n_errors = 0;
  int         frame_err = 0;
  int         rst_events = 0;
  logic [7:0] rx_q [$];

  uart_tap_tx #(.SYSTEM_CLOCK(SYS), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch0_valid (ch0_valid),
    .ch0_data  (ch0_data),
    .ch1_valid (ch1_valid),
    .ch1_data  (ch1_data),
    .dout      (dout),
    .busy      (busy),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge rst) rst_events++;

  // Line receiver: finds a start bit, samples mid-bit, drops frames cut by reset.
  initial begin
    logic [7:0] b;
    logic       bad;
    int         ev;
    forever begin
      @(negedge clk);
      if (rst && dout === 1'b0) begin
        ev  = rst_events;
        bad = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        if (dout !== 1'b0) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = dout;
        end
        repeat (DIV) @(negedge clk);
        if (dout !== 1'b1) bad = 1'b1;
        if (ev == rst_events) begin
          if (bad) frame_err++;
          else     rx_q.push_back(b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset dout", dout, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset drop_cnt", drop_cnt, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse(input logic a, input logic [7:0] ad, input logic b, input logic [7:0] bd);
    @(negedge clk);
    ch0_valid = a; ch0_data = ad;
    ch1_valid = b; ch1_data = bd;
    @(negedge clk);
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic            c0v;
    logic [7:0]      c0d;
    logic            c1v;
    logic [7:0]      c1d;
    int              n;     // byte count with tags
    logic [3:0][7:0] exp;   // tagged line order
  } vec_t;

  function automatic vec_t mk(logic a, logic [7:0] ad, logic b, logic [7:0] bd, int n,
                              logic [7:0] e0, logic [7:0] e1, logic [7:0] e2, logic [7:0] e3);
    vec_t v;
    v.c0v = a; v.c0d = ad; v.c1v = b; v.c1d = bd; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  initial begin
    vec_t       vecs [6];
    logic [7:0] exp_q [$];
    int         lat, bcnt, guard, c;

    vecs[0] = mk(1'b1, 8'h5A, 1'b0, 8'h00, 2, 8'h41, 8'h5A, 8'h00, 8'h00);
    vecs[1] = mk(1'b0, 8'h00, 1'b1, 8'hA5, 2, 8'h42, 8'hA5, 8'h00, 8'h00);
    vecs[2] = mk(1'b1, 8'h11, 1'b1, 8'h22, 4, 8'h41, 8'h11, 8'h42, 8'h22);
    vecs[3] = mk(1'b1, 8'h00, 1'b0, 8'h00, 2, 8'h41, 8'h00, 8'h00, 8'h00);
    vecs[4] = mk(1'b0, 8'h00, 1'b1, 8'hFF, 2, 8'h42, 8'hFF, 8'h00, 8'h00);
    vecs[5] = mk(1'b1, 8'h80, 1'b1, 8'h01, 4, 8'h41, 8'h80, 8'h42, 8'h01);

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("por dout", dout, 1'b1);
    check("por busy", busy, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Latency and busy window of a single capture.
    apply_reset();
    rx_q.delete();
    @(negedge clk);
    ch0_valid = 1'b1; ch0_data = 8'h5A;
    @(posedge clk); #1;
    ch0_valid = 1'b0;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (dout !== 1'b0 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    check_range("start latency", lat, 1, 3);
    guard = 0;
    while (busy === 1'b1 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
      if (busy) bcnt++;
    end
    check("busy falls", busy, 1'b0);
    check_range("busy cycles", bcnt, FRAMES * 10 * DIV, FRAMES * 10 * DIV + 4);
    repeat (4) @(negedge clk);
    check("single size", rx_q.size(), FRAMES);
    if (rx_q.size() == FRAMES) check("single data", rx_q[FRAMES-1], 8'h5A);
    if (TAG_EN && rx_q.size() == FRAMES) check("single tag", rx_q[0], 8'h41);

    // Table of single-cycle strobe patterns.
    for (int v = 0; v < 6; v++) begin
      rx_q.delete();
      exp_q.delete();
      for (int k = 0; k < vecs[v].n; k++)
        if (TAG_EN || k[0]) exp_q.push_back(vecs[v].exp[k]);
      pulse(vecs[v].c0v, vecs[v].c0d, vecs[v].c1v, vecs[v].c1d);
      wait_idle(400, $sformatf("vec%0d idle", v));
      check($sformatf("vec%0d size", v), rx_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
        check($sformatf("vec%0d byte%0d", v, k), rx_q[k], exp_q[k]);
      check($sformatf("vec%0d overflow", v), overflow, 1'b0);
    end

    // 20 consecutive ch1 strobes into a 16-deep FIFO.
    apply_reset();
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ch1_valid = 1'b1; ch1_data = 8'(8'h60 + i);
    end
    @(negedge clk);
    ch1_valid = 1'b0;
    check("burst overflow", overflow, 1'b1);
    check("burst drop_cnt", drop_cnt, 8'd3);
    wait_idle(3000, "burst idle");
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      if (TAG_EN) exp_q.push_back(8'h42);
      exp_q.push_back(8'(8'h60 + i));
    end
    check("burst size", rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      check($sformatf("burst byte%0d", k), rx_q[k], exp_q[k]);

    // Drop counter saturation, then reset discards the backlog.
    apply_reset();
    for (int i = 0; i < 350; i++) begin
      @(negedge clk);
      ch0_valid = 1'b1; ch0_data = 8'(i);
    end
    @(negedge clk);
    ch0_valid = 1'b0;
    check("sat drop_cnt", drop_cnt, 8'hFF);
    check("sat overflow", overflow, 1'b1);
    apply_reset();
    rx_q.delete();
    repeat (100) @(negedge clk);
    check("flush nothing sent", rx_q.size(), 0);
    check("flush busy", busy, 1'b0);

    // Reset in the middle of a low data bit, then a clean frame.
    apply_reset();
    rx_q.delete();
    pulse(1'b1, 8'h00, 1'b0, 8'h00);
    c = 0;
    while (dout !== 1'b0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    repeat (2 * DIV + DIV / 2) @(negedge clk);
    check("abort pre dout", dout, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("abort dout", dout, 1'b1);
    check("abort busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("abort discarded", rx_q.size(), 0);
    pulse(1'b1, 8'h33, 1'b0, 8'h00);
    wait_idle(400, "after abort idle");
    check("after abort size", rx_q.size(), FRAMES);
    if (rx_q.size() == FRAMES) check("after abort data", rx_q[FRAMES-1], 8'h33);

    check("framing errors", frame_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
